pio_cmd_sequencer: RTL and testbench

//  Owns the PIO command port (action/din/index/mindex). On start it loads

---
 rtl/pio_cmd_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_pio_cmd_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module : pio_cmd_sequencer
// Loads program then config words into the PIO command port, then
// round-robin arbitrates the port between runtime requesters.
// Rev    : 1.0
// ============================================================================
module pio_cmd_sequencer #(
  parameter int NREQ       = 2,
  parameter int PROG_LEN   = 32,
  parameter int CONF_DEPTH = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  output logic [4:0]           prog_addr_o,
  input  logic [15:0]          prog_data_i,
  output logic [4:0]           conf_addr_o,
  input  logic [37:0]          conf_data_i,
  input  logic [5:0]           conf_len_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [4*NREQ-1:0]    req_action_i,
  input  logic [32*NREQ-1:0]   req_din_i,
  input  logic [5*NREQ-1:0]    req_index_i,
  input  logic [2*NREQ-1:0]    req_mindex_i,
  output logic [3:0]           pio_action_o,
  output logic [31:0]          pio_din_o,
  output logic [4:0]           pio_index_o,
  output logic [1:0]           pio_mindex_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PROG_RD = 3'd1,
    S_PROG_WR = 3'd2,
    S_CONF_RD = 3'd3,
    S_CONF_WR = 3'd4,
    S_RUN     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  p_q, p_d, c_q, c_d, clen_q, clen_d;
  logic [1:0]  rr_q, rr_d;
  logic        done_q;
  logic [3:0]  act_q, act_d;
  logic [31:0] din_q, din_d;
  logic [4:0]  idx_q, idx_d;
  logic [1:0]  mix_q, mix_d;

  logic [3:0]   valid_pad, ready_pad;
  logic [15:0]  act_pad;
  logic [127:0] din_pad;
  logic [19:0]  idx_pad;
  logic [7:0]   mix_pad;
  logic [2:0]   cand;
  logic [1:0]   win;
  logic         found, accept;
  logic [5:0]   clen_start;

  // Requester buses padded to the 4-requester maximum so slices are fixed-width.
  assign valid_pad  = 4'(req_valid_i);
  assign act_pad    = 16'(req_action_i);
  assign din_pad    = 128'(req_din_i);
  assign idx_pad    = 20'(req_index_i);
  assign mix_pad    = 8'(req_mindex_i);
  assign clen_start = (conf_len_i > 6'(CONF_DEPTH)) ? 6'(CONF_DEPTH) : conf_len_i;

  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    cand  = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand = 3'(rr_q) + 3'(k);
      if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
      if (!found && valid_pad[cand[1:0]]) begin
        found = 1'b1;
        win   = cand[1:0];
      end
    end
  end

  // A start in RUN wins over any pending request.
  assign accept      = found && (state_q == S_RUN) && !start_i;
  assign ready_pad   = accept ? (4'b0001 << win) : 4'b0000;
  assign req_ready_o = ready_pad[NREQ-1:0];

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    c_d     = c_q;
    clen_d  = clen_q;
    rr_d    = rr_q;
    act_d   = 4'd0;
    din_d   = 32'd0;
    idx_d   = 5'd0;
    mix_d   = 2'd0;
    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_PROG_RD: state_d = S_PROG_WR;
      S_PROG_WR: begin
        act_d = 4'd1;
        din_d = {16'b0, prog_data_i};
        idx_d = p_q[4:0];
        if (p_q == 6'(PROG_LEN - 1)) begin
          c_d     = 6'd0;
          state_d = (clen_q == 6'd0) ? S_RUN : S_CONF_RD;
        end else begin
          p_d     = p_q + 6'd1;
          state_d = S_PROG_RD;
        end
      end
      S_CONF_RD: state_d = S_CONF_WR;
      S_CONF_WR: begin
        act_d = conf_data_i[35:32];
        din_d = conf_data_i[31:0];
        mix_d = conf_data_i[37:36];
        if (c_q == clen_q - 6'd1) begin
          state_d = S_RUN;
        end else begin
          c_d     = c_q + 6'd1;
          state_d = S_CONF_RD;
        end
      end
      S_RUN: begin
        if (accept) begin
          act_d = act_pad[{win, 2'b00} +: 4];
          din_d = din_pad[{win, 5'b00000} +: 32];
          idx_d = idx_pad[5'(win) * 5'd5 +: 5];
          mix_d = mix_pad[{win, 1'b0} +: 2];
          rr_d  = (win == 2'(NREQ - 1)) ? 2'd0 : win + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start_i && (state_q == S_IDLE || state_q == S_RUN)) begin
      state_d = S_PROG_RD;
      p_d     = 6'd0;
      clen_d  = clen_start;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      p_q     <= 6'd0;
      c_q     <= 6'd0;
      clen_q  <= 6'd0;
      rr_q    <= 2'd0;
      done_q  <= 1'b0;
      act_q   <= 4'd0;
      din_q   <= 32'd0;
      idx_q   <= 5'd0;
      mix_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      c_q     <= c_d;
      clen_q  <= clen_d;
      rr_q    <= rr_d;
      // done trails entry into RUN by one cycle and drops as soon as a reload starts.
      done_q  <= (state_q == S_RUN) && (state_d == S_RUN);
      act_q   <= act_d;
      din_q   <= din_d;
      idx_q   <= idx_d;
      mix_q   <= mix_d;
    end
  end

  assign prog_addr_o  = (state_q == S_PROG_RD) ? p_q[4:0] : 5'd0;
  assign conf_addr_o  = (state_q == S_CONF_RD) ? c_q[4:0] : 5'd0;
  assign busy_o       = (state_q == S_PROG_RD) || (state_q == S_PROG_WR) ||
                        (state_q == S_CONF_RD) || (state_q == S_CONF_WR);
  assign done_o       = done_q;
  assign pio_action_o = act_q;
  assign pio_din_o    = din_q;
  assign pio_index_o  = idx_q;
  assign pio_mindex_o = mix_q;

endmodule
`default_nettype wire

// File: tb/tb_pio_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_pio_cmd_sequencer
// Directed bench with a schedule-based scoreboard of expected PIO writes.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pio_cmd_sequencer;
  localparam int NREQ = 2, PROG_LEN = 32, CONF_DEPTH = 32;

  logic clk = 1'b0;
  logic reset, start;
  logic [4:0] prog_addr, conf_addr;
  logic [15:0] prog_data;
  logic [37:0] conf_data;
  logic [5:0] conf_len;
  logic busy, done;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [4*NREQ-1:0] req_action;
  logic [32*NREQ-1:0] req_din;
  logic [5*NREQ-1:0] req_index;
  logic [2*NREQ-1:0] req_mindex;
  logic [3:0] pio_action;
  logic [31:0] pio_din;
  logic [4:0] pio_index;
  logic [1:0] pio_mindex;

  pio_cmd_sequencer #(.NREQ(NREQ), .PROG_LEN(PROG_LEN), .CONF_DEPTH(CONF_DEPTH)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .prog_addr_o(prog_addr), .prog_data_i(prog_data),
    .conf_addr_o(conf_addr), .conf_data_i(conf_data), .conf_len_i(conf_len),
    .busy_o(busy), .done_o(done),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_action_i(req_action), .req_din_i(req_din),
    .req_index_i(req_index), .req_mindex_i(req_mindex),
    .pio_action_o(pio_action), .pio_din_o(pio_din),
    .pio_index_o(pio_index), .pio_mindex_o(pio_mindex)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] prog_rom [32];
  logic [37:0] conf_rom [32];
  always @(posedge clk) begin
    prog_data <= prog_rom[prog_addr];
    conf_data <= conf_rom[conf_addr];
  end

  int checks = 0, passes = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cyc=%0d: got %0h, expected %0h", nm, cyc, act, exp);
  endtask

  // Scoreboard: every PIO write the rules predict, tagged with the cycle it must appear in.
  typedef struct {
    int         cyc;
    logic [3:0] a;
    logic [31:0] d;
    logic [4:0] i;
    logic [1:0] m;
  } wr_t;
  wr_t q[$];
  bit  m_loaded = 0;
  int  m_ts = 0, m_n = 0, m_rr = 0;

  always @(negedge clk) begin : cmp
    int n, win, clen;
    bit run;
    logic [NREQ-1:0] eg;
    wr_t w;
    n = cyc;
    if (reset) begin
      chk("reset pio_action", pio_action, 0);
      chk("reset pio_din", pio_din, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset addrs", {prog_addr, conf_addr}, 0);
      chk("reset req_ready", req_ready, 0);
      q.delete();
      m_loaded = 0;
      m_rr = 0;
    end else begin
      run = m_loaded && (n >= m_ts + 2 * m_n);
      chk("busy", busy, (m_loaded && n >= m_ts && n <= m_ts + 2 * m_n - 1) ? 1 : 0);
      chk("done", done, (m_loaded && n >= m_ts + 2 * m_n + 1) ? 1 : 0);
      chk("busy&done", busy & done, 0);
      if (q.size() > 0 && q[0].cyc == n) begin
        chk("pio_action", pio_action, q[0].a);
        chk("pio_din", pio_din, q[0].d);
        chk("pio_index", pio_index, q[0].i);
        chk("pio_mindex", pio_mindex, q[0].m);
        void'(q.pop_front());
      end else begin
        chk("pio_action nop", pio_action, 0);
      end
      eg = '0;
      win = -1;
      if (run && !start) begin
        for (int k = 0; k < NREQ; k++) begin
          if (win < 0 && req_valid[(m_rr + k) % NREQ]) win = (m_rr + k) % NREQ;
        end
      end
      if (win >= 0) eg[win] = 1'b1;
      chk("req_ready", req_ready, eg);
      if (win >= 0) begin
        w.cyc = n + 1;
        w.a = req_action[4*win +: 4];
        w.d = req_din[32*win +: 32];
        w.i = req_index[5*win +: 5];
        w.m = req_mindex[2*win +: 2];
        q.push_back(w);
        m_rr = (win + 1) % NREQ;
      end
      if (start && (!m_loaded || run)) begin
        clen = (int'(conf_len) > CONF_DEPTH) ? CONF_DEPTH : int'(conf_len);
        m_loaded = 1;
        m_ts = n + 1;
        m_n = PROG_LEN + clen;
        for (int k = 0; k < PROG_LEN; k++) begin
          w.cyc = m_ts + 2 + 2 * k;
          w.a = 4'd1;
          w.d = {16'b0, prog_rom[k]};
          w.i = 5'(k);
          w.m = 2'd0;
          q.push_back(w);
        end
        for (int j = 0; j < clen; j++) begin
          w.cyc = m_ts + 2 + 2 * (PROG_LEN + j);
          w.a = conf_rom[j][35:32];
          w.d = conf_rom[j][31:0];
          w.i = 5'd0;
          w.m = conf_rom[j][37:36];
          q.push_back(w);
        end
      end
    end
  end

  task automatic do_start(input logic [5:0] cl, input logic [NREQ-1:0] v,
                          output int t0, output logic [NREQ-1:0] rdy_at, output logic busy_next);
    @(posedge clk); #2 start = 1'b1; conf_len = cl; req_valid = v;
    #1 rdy_at = req_ready;
    @(posedge clk); #2 start = 1'b0; req_valid = '0;
    t0 = cyc;
    busy_next = busy;
  endtask

  task automatic watch_load(input int t0, input int budget, output int first_cyc,
                            output int first_idx, output int nwr, output int done_cyc);
    first_cyc = -1; first_idx = -1; nwr = 0; done_cyc = -1;
    while (done_cyc < 0 && cyc < t0 + budget) begin
      @(posedge clk); #3;
      if (pio_action != 4'd0) begin
        if (first_cyc < 0) begin first_cyc = cyc; first_idx = int'(pio_index); end
        nwr++;
      end
      if (done) done_cyc = cyc;
    end
  endtask

  task automatic drive_req(input logic [NREQ-1:0] v, input int k);
    req_valid  = v;
    req_din    = {32'hBBBB_0000 + 32'(k), 32'hAAAA_0000 + 32'(k)};
    req_action = {4'h5, 4'h3};
    req_index  = {5'(20 + k), 5'(10 + k)};
    req_mindex = {2'd2, 2'd1};
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int t0, fc, fi, nw, dc;
    logic [NREQ-1:0] r0, rdy [4];
    logic bn;
    logic [31:0] dseen [4];
    for (int i = 0; i < 32; i++) begin
      prog_rom[i] = 16'h1000 + 16'(i * 257);
      conf_rom[i] = {2'(i % 4), 4'(2 + i % 14), 32'hC000_0000 + 32'(i * 4099)};
    end
    reset = 1'b1; start = 1'b0; conf_len = 6'd4;
    drive_req('0, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Full load: 32 instructions + 4 config words; conf_len change mid-load is ignored
    @(posedge clk); #2 start = 1'b1; conf_len = 6'd4;
    @(posedge clk); #2 start = 1'b0; conf_len = 6'd7;
    t0 = cyc;
    watch_load(t0, 90, fc, fi, nw, dc);
    chk("t1 first write latency", 64'(fc - t0), 2);
    chk("t1 first index", 64'(fi), 0);
    chk("t1 write count", 64'(nw), 36);
    chk("t1 done latency", 64'(dc - t0), 73);

    // Both requesters valid for 4 cycles: alternate grants, data one cycle later
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2 dseen[k] = pio_din;
      drive_req(2'b11, k);
      #1 rdy[k] = req_ready;
    end
    @(posedge clk); #2 drive_req('0, 0);
    chk("t3 grant0", rdy[0], 2'b01);
    chk("t3 grant1", rdy[1], 2'b10);
    chk("t3 grant2", rdy[2], 2'b01);
    chk("t3 grant3", rdy[3], 2'b10);
    chk("t3 din after grant0", dseen[1], 32'hAAAA_0000);
    chk("t3 din after grant1", dseen[2], 32'hBBBB_0001);
    chk("t3 din after grant2", dseen[3], 32'hAAAA_0002);

    // Only requester 1, then both: pointer wraps back to 0
    @(posedge clk); #2 drive_req(2'b10, 5);
    #1 rdy[0] = req_ready;
    @(posedge clk); #2 drive_req(2'b11, 6);
    #1 rdy[1] = req_ready;
    @(posedge clk); #2 drive_req('0, 0);
    chk("t4 grant req1", rdy[0], 2'b10);
    chk("t4 grant wrap", rdy[1], 2'b01);

    // Start in RUN beats a pending request; conf_len=0 finishes right after instructions
    do_start(6'd0, 2'b01, t0, r0, bn);
    chk("t5 ready during start", r0, 2'b00);
    chk("t5 busy next cycle", bn, 1);
    watch_load(t0, 80, fc, fi, nw, dc);
    chk("t5 first index", 64'(fi), 0);
    chk("t2 len0 write count", 64'(nw), 32);
    chk("t2 len0 done latency", 64'(dc - t0), 65);

    // conf_len above depth is clamped to 32
    do_start(6'd40, 2'b00, t0, r0, bn);
    watch_load(t0, 140, fc, fi, nw, dc);
    chk("t2 len40 write count", 64'(nw), 64);
    chk("t2 len40 done latency", 64'(dc - t0), 129);

    // Start pulse mid-load is ignored; reset at word 10 aborts immediately
    do_start(6'd4, 2'b00, t0, r0, bn);
    while (cyc < t0 + 9) begin @(posedge clk); #2; end
    start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    while (cyc < t0 + 22) begin @(posedge clk); #2; end
    chk("t6 word10 action", pio_action, 1);
    chk("t6 word10 index", pio_index, 10);
    reset = 1'b1;
    #1;
    chk("t6 async action", pio_action, 0);
    chk("t6 async busy", busy, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    do_start(6'd4, 2'b00, t0, r0, bn);
    watch_load(t0, 90, fc, fi, nw, dc);
    chk("t6 reload first index", 64'(fi), 0);
    chk("t6 reload write count", 64'(nw), 36);
    chk("t6 reload done latency", 64'(dc - t0), 73);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
